// File: rtl/register_file_pkg.sv
// Shared types and helpers for the 2-read/1-write register file.
// Holds the clear-sequencer state encoding, default sizes and the
// byte-merge function used by the write path.
package register_file_pkg;

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Widest word the merge helper handles; callers zero-extend into it.
  localparam int MERGE_W    = 256;
  localparam int MERGE_BE_W = MERGE_W / 8;

  // Per-byte merge: enabled bytes take new data, disabled bytes keep the
  // old data if the entry was valid, otherwise they read back as zero.
  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0]    old_word,
    input logic [MERGE_W-1:0]    new_word,
    input logic [MERGE_BE_W-1:0] be,
    input logic                  old_valid
  );
    logic [MERGE_W-1:0] merged;
    merged = '0;
    for (int k = 0; k < MERGE_BE_W; k++) begin
      if (be[k])         merged[8*k +: 8] = new_word[8*k +: 8];
      else if (old_valid) merged[8*k +: 8] = old_word[8*k +: 8];
      else               merged[8*k +: 8] = 8'h00;
    end
    return merged;
  endfunction

endpackage

// File: rtl/register_file_clear_seq.sv
// Background clear sequencer: walks every entry index once, one per
// cycle, while holding busy high. A clear request while running is ignored.
module register_file_clear_seq
  import register_file_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_idx
);

  clr_state_e state;

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  // Clear FSM: start on request, step the index, finish after the last entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLR_IDLE;
      busy    <= 1'b0;
      clr_idx <= '0;
    end else begin
      case (state)
        CLR_IDLE: begin
          if (clear) begin
            state   <= CLR_RUN;
            busy    <= 1'b1;
            clr_idx <= '0;
          end
        end
        CLR_RUN: begin
          if (clr_idx == ADDR_W'(DEPTH - 1)) begin
            state <= CLR_IDLE;
            busy  <= 1'b0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        default: begin
          state <= CLR_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Busy is exactly the set of cycles in which an entry is being cleared.
  assign clr_en = busy;

endmodule

// File: rtl/register_file_2r1w.sv
// DEPTH x DATA_W register file: two registered read ports, one byte-enabled
// write port, per-entry valid bits and a background clear sequencer.
// Optional macro REGISTER_FILE_BYPASS_EN: same-cycle read of the address
// being written returns the merged post-write value instead of the old one.
module register_file_2r1w
  import register_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd0_en,
  input  logic [ADDR_W-1:0]   rd0_addr,
  output logic [DATA_W-1:0]   rd0_data,
  output logic                rd0_valid,
  input  logic                rd1_en,
  input  logic [ADDR_W-1:0]   rd1_addr,
  output logic [DATA_W-1:0]   rd1_data,
  output logic                rd1_valid,
  input  logic                clear,
  output logic                busy,
  output logic                wr_drop
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  entry_valid;

  logic              clr_en;
  logic [ADDR_W-1:0] clr_idx;

  logic              wr_accept;
  logic [DATA_W-1:0] wr_merged;

  logic              rd_en_v       [2];
  logic [ADDR_W-1:0] rd_addr_v     [2];
  logic [DATA_W-1:0] rd_data_next  [2];
  logic              rd_valid_next [2];
  logic [DATA_W-1:0] rd_data_q     [2];
  logic              rd_valid_q    [2];

  register_file_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .busy    (busy),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

  // A write with no byte enabled is a no-op and must not set the valid bit.
  assign wr_accept = wr_en && !busy && (|wr_be);
  assign wr_merged = DATA_W'(byte_merge(MERGE_W'(mem[wr_addr]), MERGE_W'(wr_data),
                                        MERGE_BE_W'(wr_be), entry_valid[wr_addr]));

  assign rd_en_v[0]   = rd0_en;
  assign rd_en_v[1]   = rd1_en;
  assign rd_addr_v[0] = rd0_addr;
  assign rd_addr_v[1] = rd1_addr;

  // NOTE: the data array has no reset; valid bits mask stale contents, so the
  // array stays a plain storage block without a reset tree.
  // Storage update: clear sequencer zeroes one entry, or an accepted write lands.
  always_ff @(posedge clock) begin
    if (clr_en)    mem[clr_idx] <= '0;
    if (wr_accept) mem[wr_addr] <= wr_merged;
  end

  // Valid tracking: reset drops everything, clear drops one entry, writes set.
  always_ff @(posedge clock) begin
    if (reset) begin
      entry_valid <= '0;
    end else begin
      if (clr_en)    entry_valid[clr_idx] <= 1'b0;
      if (wr_accept) entry_valid[wr_addr] <= 1'b1;
    end
  end

  // Sticky flag for writes rejected while the clear sequence runs.
  always_ff @(posedge clock) begin
    if (reset)              wr_drop <= 1'b0;
    else if (wr_en && busy) wr_drop <= 1'b1;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  // Next read value per port: masked array contents, optionally bypassed.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_valid_next[p] = entry_valid[rd_addr_v[p]];
      rd_data_next[p]  = entry_valid[rd_addr_v[p]] ? mem[rd_addr_v[p]] : '0;
`ifdef REGISTER_FILE_BYPASS_EN
      if (wr_accept && (rd_addr_v[p] == wr_addr)) begin
        rd_data_next[p]  = wr_merged;
        rd_valid_next[p] = 1'b1;
      end
`endif
    end
  end

  // Read registers: load on enable, otherwise hold.
  always_ff @(posedge clock) begin
    for (int p = 0; p < 2; p++) begin
      if (reset) begin
        rd_data_q[p]  <= '0;
        rd_valid_q[p] <= 1'b0;
      end else if (rd_en_v[p]) begin
        rd_data_q[p]  <= rd_data_next[p];
        rd_valid_q[p] <= rd_valid_next[p];
      end
    end
  end

  assign rd0_data  = rd_data_q[0];
  assign rd0_valid = rd_valid_q[0];
  assign rd1_data  = rd_data_q[1];
  assign rd1_valid = rd_valid_q[1];

endmodule

// File: tb/tb_register_file_2r1w.sv
// Self-checking bench for register_file_2r1w (DATA_W=32, DEPTH=16).
// A behavioural model predicts both read ports each cycle; predictions are
// queued before the edge and compared after it. Directed scenarios add
// constant-value checks. Honors REGISTER_FILE_BYPASS_EN for bypass expectations.
module tb_register_file_2r1w;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int BE_W   = DATA_W / 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;
  logic              rd0_en, rd1_en;
  logic [ADDR_W-1:0] rd0_addr, rd1_addr;
  logic [DATA_W-1:0] rd0_data, rd1_data;
  logic              rd0_valid, rd1_valid;
  logic              clear;
  logic              busy;
  logic              wr_drop;

  register_file_2r1w #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .rd0_en    (rd0_en),
    .rd0_addr  (rd0_addr),
    .rd0_data  (rd0_data),
    .rd0_valid (rd0_valid),
    .rd1_en    (rd1_en),
    .rd1_addr  (rd1_addr),
    .rd1_data  (rd1_data),
    .rd1_valid (rd1_valid),
    .clear     (clear),
    .busy      (busy),
    .wr_drop   (wr_drop)
  );

  always #5 clock = ~clock;

  typedef struct {
    string             tag;
    int                port;
    logic [DATA_W-1:0] data;
    logic              vld;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [DATA_W-1:0] m_mem      [DEPTH];
  bit                m_valid    [DEPTH];
  bit                m_busy     = 1'b0;
  int                m_idx      = 0;
  bit                m_drop     = 1'b0;
  logic [DATA_W-1:0] m_rd_data  [2];
  bit                m_rd_valid [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd0_en = 1'b0; rd0_addr = '0; rd1_en = 1'b0; rd1_addr = '0; clear = 1'b0;
  endtask

  task automatic set_wr(input int a, input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d; wr_be = be;
  endtask

  // Predict this edge from current inputs, advance one cycle, compare.
  task automatic step(input string tag);
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] d;
    bit                v;
    bit                acc;
    int                wa;
    int                ra [2];
    bit                re [2];
    exp_t              e;

    ra[0] = int'(rd0_addr); ra[1] = int'(rd1_addr);
    re[0] = rd0_en;         re[1] = rd1_en;
    wa    = int'(wr_addr);
    acc   = wr_en && !m_busy && (wr_be != '0);
    merged = '0;
    for (int k = 0; k < BE_W; k++)
      merged[8*k +: 8] = wr_be[k] ? wr_data[8*k +: 8]
                                  : (m_valid[wa] ? m_mem[wa][8*k +: 8] : 8'h00);

    for (int p = 0; p < 2; p++) begin
      if (reset) begin
        m_rd_data[p] = '0; m_rd_valid[p] = 1'b0;
      end else if (re[p]) begin
        d = m_valid[ra[p]] ? m_mem[ra[p]] : '0;
        v = m_valid[ra[p]];
`ifdef REGISTER_FILE_BYPASS_EN
        if (acc && ra[p] == wa) begin d = merged; v = 1'b1; end
`endif
        m_rd_data[p] = d; m_rd_valid[p] = v;
      end
      e.tag = tag; e.port = p; e.data = m_rd_data[p]; e.vld = m_rd_valid[p];
      sb.push_back(e);
    end

    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      m_busy = 1'b0; m_drop = 1'b0; m_idx = 0;
    end else begin
      if (wr_en && m_busy) m_drop = 1'b1;
      if (acc) begin m_mem[wa] = merged; m_valid[wa] = 1'b1; end
      if (m_busy) begin
        m_mem[m_idx] = '0; m_valid[m_idx] = 1'b0;
        if (m_idx == DEPTH - 1) m_busy = 1'b0;
        else m_idx++;
      end else if (clear) begin
        m_busy = 1'b1; m_idx = 0;
      end
    end

    @(posedge clock);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.port == 0) begin
        check($sformatf("%s.rd0_data", e.tag), 64'(rd0_data), 64'(e.data));
        check($sformatf("%s.rd0_valid", e.tag), 64'(rd0_valid), 64'(e.vld));
      end else begin
        check($sformatf("%s.rd1_data", e.tag), 64'(rd1_data), 64'(e.data));
        check($sformatf("%s.rd1_valid", e.tag), 64'(rd1_valid), 64'(e.vld));
      end
    end
    check($sformatf("%s.busy", tag), 64'(busy), 64'(m_busy));
    check($sformatf("%s.wr_drop", tag), 64'(wr_drop), 64'(m_drop));
  endtask

  task automatic fill_all();
    for (int i = 0; i < DEPTH; i++) begin
      idle(); set_wr(i, DATA_W'(32'h01010101 * (i + 1)), 4'b1111);
      step($sformatf("fill%0d", i));
    end
  endtask

  int cnt;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 1'b0; m_mem[i] = '0; end
    for (int p = 0; p < 2; p++) begin m_rd_data[p] = '0; m_rd_valid[p] = 1'b0; end

    // Reset, then read an unwritten entry.
    idle(); reset = 1'b1; step("reset");
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_wr_drop", 64'(wr_drop), 64'(0));
    idle(); rd0_en = 1'b1; rd0_addr = 4'd3; step("rd_unwritten");
    check("rd_unwritten_data", 64'(rd0_data), 64'h0);
    check("rd_unwritten_valid", 64'(rd0_valid), 64'h0);

    idle(); set_wr(3, 32'h000000A5, 4'b0001); step("wr3");
    idle(); rd0_en = 1'b1; rd0_addr = 4'd3; step("rd3");
    check("rd3_data", 64'(rd0_data), 64'hA5);
    check("rd3_valid", 64'(rd0_valid), 64'h1);

    // Byte enables, merge onto valid and onto invalid entries.
    idle(); set_wr(5, 32'h11223344, 4'b1111); step("wr5a");
    idle(); set_wr(5, 32'hAABBCCDD, 4'b0101); step("wr5b");
    idle(); rd1_en = 1'b1; rd1_addr = 4'd5; step("rd5");
    check("be_merge", 64'(rd1_data), 64'h11BB33DD);
    idle(); set_wr(6, 32'h1234EE78, 4'b0010); step("wr6");
    idle(); rd0_en = 1'b1; rd0_addr = 4'd6; step("rd6");
    check("be_invalid_zero", 64'(rd0_data), 64'h0000EE00);

    // wr_be=0 is a no-op; reads with enables low hold.
    idle(); set_wr(3, 32'hFFFFFFFF, 4'b0000); step("wr_nobe");
    idle(); rd0_en = 1'b1; rd0_addr = 4'd3; step("rd_nobe");
    check("nobe_noop", 64'(rd0_data), 64'hA5);
    idle(); rd0_addr = 4'd5; rd1_addr = 4'd6; step("hold");

    // Dual port same address.
    idle(); set_wr(2, 32'h0000007E, 4'b1111); step("wr2");
    idle(); rd0_en = 1'b1; rd1_en = 1'b1; rd0_addr = 4'd2; rd1_addr = 4'd2; step("dual");
    check("dual_rd0", 64'(rd0_data), 64'h7E);
    check("dual_rd1", 64'(rd1_data), 64'h7E);
    check("dual_vld", 64'({rd0_valid, rd1_valid}), 64'h3);

    // Same-cycle read/write to one address.
    idle(); set_wr(9, 32'h00000012, 4'b1111); step("wr9");
    idle(); set_wr(9, 32'h00000055, 4'b1111);
    rd0_en = 1'b1; rd0_addr = 4'd9; rd1_en = 1'b1; rd1_addr = 4'd2; step("bypass");
`ifdef REGISTER_FILE_BYPASS_EN
    check("bypass_data", 64'(rd0_data), 64'h55);
`else
    check("bypass_data", 64'(rd0_data), 64'h12);
`endif
    check("bypass_other_port", 64'(rd1_data), 64'h7E);

    // Full clear with a dropped write and an ignored re-request.
    fill_all();
    idle(); clear = 1'b1; step("clear_start");
    cnt = 0;
    while (busy === 1'b1 && cnt < 40) begin
      cnt++;
      idle();
      rd0_en = 1'b1; rd0_addr = ADDR_W'(cnt - 1);
      rd1_en = 1'b1; rd1_addr = 4'd15;
      if (cnt == 3) set_wr(15, 32'hDEADBEEF, 4'b1111);
      if (cnt == 5) clear = 1'b1;
      step($sformatf("clear_c%0d", cnt));
    end
    check("busy_cycles", 64'(cnt), 64'd16);
    check("drop_sticky", 64'(wr_drop), 64'h1);
    for (int i = 0; i < DEPTH; i += 2) begin
      idle(); rd0_en = 1'b1; rd1_en = 1'b1;
      rd0_addr = ADDR_W'(i); rd1_addr = ADDR_W'(i + 1);
      step($sformatf("post_clear%0d", i));
      check($sformatf("post_clear_vld%0d", i), 64'({rd0_valid, rd1_valid}), 64'h0);
      check($sformatf("post_clear_data%0d", i), 64'({rd0_data, rd1_data}), 64'h0);
    end
    idle(); set_wr(4, 32'h0000CAFE, 4'b0011); step("wr_after_clear");
    idle(); rd0_en = 1'b1; rd0_addr = 4'd4; step("rd_after_clear");
    check("wr_after_clear", 64'(rd0_data), 64'hCAFE);

    // Reset in the middle of a clear.
    fill_all();
    idle(); clear = 1'b1; step("clear2_start");
    for (int c = 2; c <= 6; c++) begin idle(); step($sformatf("clear2_c%0d", c)); end
    idle(); set_wr(0, 32'h1, 4'b1111); step("clear2_drop");
    idle(); reset = 1'b1; step("mid_reset");
    check("mid_reset_busy", 64'(busy), 64'h0);
    check("mid_reset_drop", 64'(wr_drop), 64'h0);
    for (int i = 0; i < DEPTH; i += 2) begin
      idle(); rd0_en = 1'b1; rd1_en = 1'b1;
      rd0_addr = ADDR_W'(i); rd1_addr = ADDR_W'(i + 1);
      step($sformatf("post_reset%0d", i));
      check($sformatf("post_reset_vld%0d", i), 64'({rd0_valid, rd1_valid}), 64'h0);
    end
    // Stale contents behind an invalid entry must not leak into a partial write.
    idle(); set_wr(12, 32'hFFFFFF99, 4'b0001); step("wr12");
    idle(); rd1_en = 1'b1; rd1_addr = 4'd12; step("rd12");
    check("stale_masked", 64'(rd1_data), 64'h99);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
